// File: rtl/regfile_sequencer.sv
// Multicycle register-transfer initiator (MOVI/MOV/ADD/AND) driving an 8x16 register file.
// Optional {V,N,Z} flag logic is built only when REGSEQ_FLAGS_EN is defined.
module regfile_sequencer #(
  parameter int DW   = 16,
  parameter int IMMW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s,
  input  logic [1:0]      op,
  input  logic [2:0]      rd,
  input  logic [2:0]      rn,
  input  logic [2:0]      rm,
  input  logic [IMMW-1:0] imm,
  input  logic [DW-1:0]   rf_rdata,
  output logic [2:0]      readnum,
  output logic [2:0]      writenum,
  output logic            write,
  output logic [DW-1:0]   data_in,
  output logic            w,
  output logic [2:0]      flags,
  output logic [1:0]      dbg_state
);

  // Handshake: the op is accepted on a rising edge where w=1 and s=1.
  // w stays 0 until the write has been committed by the file.
  localparam logic [1:0] OP_MOVI = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_AND  = 2'b11;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'b00,
    ST_READ_N = 2'b01,
    ST_READ_M = 2'b10,
    ST_WRITE  = 2'b11
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]    r_op;
  logic [2:0]    r_rd;
  logic [2:0]    r_rn;
  logic [2:0]    r_rm;
  logic [DW-1:0] r_a;
  logic [DW-1:0] r_c;
  logic [2:0]    r_readnum_hold;
  logic [2:0]    r_wn_hold;
  logic [DW-1:0] r_din_hold;

  logic [DW-1:0] w_imm_sx;
  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_result;

  assign w_imm_sx  = {{(DW-IMMW){imm[IMMW-1]}}, imm};
  assign w_sum     = r_a + rf_rdata;
  assign dbg_state = r_state;

  always_comb begin
    w_result = rf_rdata;
    case (r_op)
      OP_MOV:  w_result = rf_rdata;
      OP_ADD:  w_result = w_sum;
      OP_AND:  w_result = r_a & rf_rdata;
      default: w_result = rf_rdata;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT: begin
        if (s) begin
          case (op)
            OP_MOVI: w_next = ST_WRITE;
            OP_MOV:  w_next = ST_READ_M;
            default: w_next = ST_READ_N;
          endcase
        end
      end
      ST_READ_N: w_next = ST_READ_M;
      ST_READ_M: w_next = ST_WRITE;
      ST_WRITE:  w_next = ST_WAIT;
      default:   w_next = ST_WAIT;
    endcase
  end

  // Moore outputs; the hold registers carry the last driven value outside the active state.
  always_comb begin
    write    = 1'b0;
    w        = 1'b0;
    readnum  = r_readnum_hold;
    writenum = r_wn_hold;
    data_in  = r_din_hold;
    case (r_state)
      ST_WAIT:   w = 1'b1;
      ST_READ_N: readnum = r_rn;
      ST_READ_M: readnum = r_rm;
      ST_WRITE: begin
        write    = 1'b1;
        writenum = r_rd;
        data_in  = r_c;
      end
      default: w = 1'b1;
    endcase
  end

  // Operand latches and datapath; MOVI loads C directly at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op           <= '0;
      r_rd           <= '0;
      r_rn           <= '0;
      r_rm           <= '0;
      r_a            <= '0;
      r_c            <= '0;
      r_readnum_hold <= '0;
      r_wn_hold      <= '0;
      r_din_hold     <= '0;
    end else begin
      case (r_state)
        ST_WAIT: begin
          if (s) begin
            r_op <= op;
            r_rd <= rd;
            r_rn <= rn;
            r_rm <= rm;
            if (op == OP_MOVI) begin
              r_c <= w_imm_sx;
            end
          end
        end
        ST_READ_N: begin
          r_a            <= rf_rdata;
          r_readnum_hold <= r_rn;
        end
        ST_READ_M: begin
          r_c            <= w_result;
          r_readnum_hold <= r_rm;
        end
        ST_WRITE: begin
          r_wn_hold  <= r_rd;
          r_din_hold <= r_c;
        end
        default: ;
      endcase
    end
  end

`ifdef REGSEQ_FLAGS_EN
  logic       r_v_pend;
  logic [2:0] r_flags;
  logic       w_add_ovf;

  // Overflow: both addends share a sign that the wrapped sum does not.
  assign w_add_ovf = (r_a[DW-1] == rf_rdata[DW-1]) && (w_sum[DW-1] != r_a[DW-1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v_pend <= 1'b0;
      r_flags  <= 3'b000;
    end else begin
      if (r_state == ST_READ_M) begin
        r_v_pend <= (r_op == OP_ADD) && w_add_ovf;
      end
      if ((r_state == ST_WRITE) && r_op[1]) begin
        r_flags <= {r_v_pend, r_c[DW-1], (r_c == '0)};
      end
    end
  end

  assign flags = r_flags;
`else
  assign flags = 3'b000;
`endif

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: behavioural register file, directed table, corner sequences, random ops.
module tb_regfile_sequencer;
  localparam int DW   = 16;
  localparam int IMMW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            s;
  logic [1:0]      op;
  logic [2:0]      rd, rn, rm;
  logic [IMMW-1:0] imm;
  logic [DW-1:0]   rf_rdata;
  logic [2:0]      readnum, writenum;
  logic            write;
  logic [DW-1:0]   data_in;
  logic            w;
  logic [2:0]      flags;
  logic [1:0]      dbg_state;

  regfile_sequencer #(.DW(DW), .IMMW(IMMW)) dut (
    .clk(clk), .reset(reset), .s(s), .op(op), .rd(rd), .rn(rn), .rm(rm), .imm(imm),
    .rf_rdata(rf_rdata), .readnum(readnum), .writenum(writenum), .write(write),
    .data_in(data_in), .w(w), .flags(flags), .dbg_state(dbg_state)
  );

  // ---- clock / environment register file ----
  always #5 clk = ~clk;

  logic [DW-1:0] rf [8];
  assign rf_rdata = rf[readnum];
  always @(posedge clk) if (write) rf[writenum] <= data_in;

  // ---- reference model state ----
  logic [DW-1:0] exp_regs [8];
  logic [2:0]    exp_flags;
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] model_result(input logic [1:0] o, input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b, input logic [IMMW-1:0] im);
    int sv;
    case (o)
      2'd0: begin sv = int'($signed(im)); return DW'(sv); end
      2'd1: return b;
      2'd2: return DW'(int'(a) + int'(b));
      default: return a & b;
    endcase
  endfunction

  function automatic logic model_ovf(input logic [DW-1:0] a, input logic [DW-1:0] b);
    int sum;
    sum = int'($signed(a)) + int'($signed(b));
    return (sum > 32767) || (sum < -32768);
  endfunction

  // ---- scoreboard on the write port ----
  logic [18:0] exp_q [$];
  logic [18:0] mon_e;
  always @(negedge clk) begin
    if (write === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_write: got writenum %0d data %0h expected no write", writenum, data_in);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_port", 32'({writenum, data_in}), 32'(mon_e));
      end
    end
  end

  task automatic preload(input logic [2:0] idx, input logic [DW-1:0] val);
    rf[idx] <= val;
    exp_regs[idx] = val;
  endtask

  // ---- driver: one complete op, checking timing, read selects and commit ----
  task automatic do_op(input logic [1:0] o, input logic [2:0] d, input logic [2:0] n,
                       input logic [2:0] m, input logic [IMMW-1:0] im);
    logic [DW-1:0] res;
    logic          v;
    int            lat;
    res = model_result(o, exp_regs[n], exp_regs[m], im);
    v   = (o == 2'd2) && model_ovf(exp_regs[n], exp_regs[m]);
    lat = (o == 2'd0) ? 2 : (o == 2'd1) ? 3 : 4;
    exp_q.push_back({d, res});
    s = 1'b1; op = o; rd = d; rn = n; rm = m; imm = im;
    @(posedge clk); #1;
    s = 1'b0;
    op = 2'($urandom_range(3, 0)); rd = 3'($urandom_range(7, 0));
    rn = 3'($urandom_range(7, 0)); rm = 3'($urandom_range(7, 0)); imm = 8'($urandom_range(255, 0));
    for (int k = 1; k < lat; k++) begin
      check("busy_w", 32'(w), 32'(0));
      check("write_en", 32'(write), 32'(k == lat - 1));
      if (o[1] && k == 1) check("readnum_n", 32'(readnum), 32'(n));
      if ((o[1] && k == 2) || (o == 2'd1 && k == 1)) check("readnum_m", 32'(readnum), 32'(m));
      @(posedge clk); #1;
    end
    check("idle_w", 32'(w), 32'(1));
    check("write_off", 32'(write), 32'(0));
    check("data_hold", 32'(data_in), 32'(res));
    check("wnum_hold", 32'(writenum), 32'(d));
    exp_regs[d] = res;
`ifdef REGSEQ_FLAGS_EN
    if (o[1]) exp_flags = {v, res[DW-1], (res == '0)};
`else
    if (v) exp_flags = 3'b000;
`endif
    check("flags", 32'(flags), 32'(exp_flags));
    check("rf_commit", 32'(rf[d]), 32'(res));
  endtask

  // ---- directed vector table ----
  typedef struct {
    logic            pre_en;
    logic [2:0]      pa;
    logic [DW-1:0]   va;
    logic [2:0]      pb;
    logic [DW-1:0]   vb;
    logic [1:0]      op;
    logic [2:0]      rd, rn, rm;
    logic [IMMW-1:0] imm;
    logic [DW-1:0]   exp_val;
    logic [2:0]      exp_fl;
  } vec_t;
  vec_t tbl [5];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'd0, 3'd3, 3'd0, 3'd0, 8'hF6, 16'hFFF6, 3'b000};
    tbl[1] = '{1'b1, 3'd1, 16'h0007, 3'd2, 16'h0009, 2'd2, 3'd1, 3'd1, 3'd2, 8'h00, 16'h0010, 3'b000};
    tbl[2] = '{1'b1, 3'd0, 16'h7FFF, 3'd1, 16'h0001, 2'd2, 3'd2, 3'd0, 3'd1, 8'h00, 16'h8000, 3'b110};
    tbl[3] = '{1'b1, 3'd4, 16'hF0F0, 3'd5, 16'h0F0F, 2'd3, 3'd6, 3'd4, 3'd5, 8'h00, 16'h0000, 3'b001};
    tbl[4] = '{1'b0, 3'd0, 16'h0000, 3'd0, 16'h0000, 2'd1, 3'd7, 3'd0, 3'd4, 8'h00, 16'hF0F0, 3'b001};

    reset = 1'b1; s = 1'b0; op = '0; rd = '0; rn = '0; rm = '0; imm = '0;
    exp_flags = 3'b000;
    for (int i = 0; i < 8; i++) preload(3'(i), '0);
    @(posedge clk); @(posedge clk); #1;
    check("rst_w", 32'(w), 32'(1));
    check("rst_write", 32'(write), 32'(0));
    check("rst_readnum", 32'(readnum), 32'(0));
    check("rst_writenum", 32'(writenum), 32'(0));
    check("rst_data_in", 32'(data_in), 32'(0));
    check("rst_flags", 32'(flags), 32'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      if (tbl[i].pre_en) begin
        preload(tbl[i].pa, tbl[i].va);
        preload(tbl[i].pb, tbl[i].vb);
      end
      do_op(tbl[i].op, tbl[i].rd, tbl[i].rn, tbl[i].rm, tbl[i].imm);
      check("tbl_result", 32'(rf[tbl[i].rd]), 32'(tbl[i].exp_val));
`ifdef REGSEQ_FLAGS_EN
      check("tbl_flags", 32'(flags), 32'(tbl[i].exp_fl));
`else
      check("tbl_flags", 32'(flags), 32'(0));
`endif
    end

    // s held high: changes while busy are ignored, re-accept one cycle after w rises
    exp_q.push_back({3'd0, 16'h0005});
    exp_q.push_back({3'd5, 16'h0022});
    s = 1'b1; op = 2'd0; rd = 3'd0; imm = 8'h05;
    @(posedge clk); #1;
    op = 2'd0; rd = 3'd5; imm = 8'h22;
    check("hold_busy_w", 32'(w), 32'(0));
    @(posedge clk); #1;
    check("hold_w_rise", 32'(w), 32'(1));
    check("hold_first_rf", 32'(rf[0]), 32'(16'h0005));
    exp_regs[0] = 16'h0005;
    @(posedge clk); #1;
    check("hold_reaccept_w", 32'(w), 32'(0));
    check("hold_reaccept_wr", 32'(write), 32'(1));
    check("hold_reaccept_wn", 32'(writenum), 32'(5));
    s = 1'b0;
    @(posedge clk); #1;
    check("hold_second_w", 32'(w), 32'(1));
    check("hold_second_rf", 32'(rf[5]), 32'(16'h0022));
    exp_regs[5] = 16'h0022;

    // reset mid-ADD (READ_M): abandon without writing
    preload(3'd1, 16'h0007);
    preload(3'd2, 16'h0009);
    s = 1'b1; op = 2'd2; rd = 3'd3; rn = 3'd1; rm = 3'd2;
    @(posedge clk); #1;
    s = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rstmid_w", 32'(w), 32'(1));
    check("rstmid_write", 32'(write), 32'(0));
    check("rstmid_readnum", 32'(readnum), 32'(0));
    check("rstmid_flags", 32'(flags), 32'(0));
    exp_flags = 3'b000;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rstmid_rf", 32'(rf[3]), 32'(exp_regs[3]));

    // reset during WRITE: write drops before the edge
    preload(3'd4, 16'h1234);
    s = 1'b1; op = 2'd0; rd = 3'd4; imm = 8'h81;
    @(posedge clk); #1;
    s = 1'b0;
    reset = 1'b1;
    #1;
    check("rstwr_write", 32'(write), 32'(0));
    check("rstwr_w", 32'(w), 32'(1));
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rstwr_rf", 32'(rf[4]), 32'(16'h1234));

    // randomized ops against the model
    for (int i = 0; i < 8; i++) preload(3'(i), 16'($urandom_range(65535, 0)));
    for (int t = 0; t < 40; t++) begin
      do_op(2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)),
            3'($urandom_range(7, 0)), 8'($urandom_range(255, 0)));
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk); #1;
      end
    end

    @(posedge clk); #1;
    check("queue_empty", 32'(exp_q.size()), 32'(0));
    for (int i = 0; i < 8; i++) check("final_rf", 32'(rf[i]), 32'(exp_regs[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
